// File: rtl/cw_pkg.sv
// Shared widths, state encoding and default best_d latency for the
// constant-weight run decoder.
package cw_pkg;

  localparam int N_W = 12;
  localparam int T_W = 5;
  localparam int D_W = 11;
  localparam int U_W = 4;

  localparam int BEST_D_LAT_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_D,
    ST_PREFIX,
    ST_SUFFIX,
    ST_EMIT,
    ST_DONE
  } cw_state_t;

  // Remaining slack for one run; 13 bits so it never wraps.
  function automatic logic [N_W:0] run_room(input logic [N_W-1:0] n,
                                            input logic [T_W-1:0] t);
    return {1'b0, n} - {{(N_W+1-T_W){1'b0}}, t};
  endfunction

endpackage

// File: rtl/golomb_suffix_shift.sv
// MSB-first remainder shifter for the Golomb suffix, with a down-counter
// that flags the final remainder bit.
module golomb_suffix_shift
  import cw_pkg::*;
#(
  parameter int R_W = N_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [U_W-1:0] u,
  input  logic           shift,
  input  logic           bit_in,
  output logic [R_W-1:0] r_next,
  output logic           last
);

  logic [R_W-2:0] r;
  logic [U_W-1:0] cnt;

  assign r_next = {r, bit_in};
  assign last   = (cnt == U_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r   <= '0;
      cnt <= '0;
    end else if (load) begin
      r   <= '0;
      cnt <= u;
    end else if (shift) begin
      r   <= r_next[R_W-2:0];
      cnt <= cnt - U_W'(1);
    end
  end

endmodule

// File: rtl/cw_run_decoder.sv
// Serial Golomb decoder producing the successive run lengths of a
// constant-weight word, with best_d driven from n_out/t_out.
//
// state  | meaning
// IDLE   | waiting for start
// WAIT_D | best_d settling on the current (n, t)
// PREFIX | consuming unary ones, acc += d per one
// SUFFIX | shifting in the u-bit remainder
// EMIT   | delta presented, waiting for delta_ready
// DONE   | one-cycle done pulse, then back to IDLE
module cw_run_decoder
  import cw_pkg::*;
#(
  parameter int BEST_D_LAT = BEST_D_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n_in,
  input  logic [T_W-1:0] t_in,
  output logic [N_W-1:0] n_out,
  output logic [T_W-1:0] t_out,
  input  logic [D_W-1:0] d,
  input  logic [U_W-1:0] u,
  input  logic           bit_in,
  input  logic           bit_valid,
  output logic           bit_ready,
  output logic [N_W-1:0] delta,
  output logic           delta_valid,
  input  logic           delta_ready,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int WC_W = 8;

  cw_state_t      state;
  logic [WC_W-1:0] wait_cnt;
  logic [N_W-1:0] acc;
  logic [D_W-1:0] d_r;
  logic [U_W-1:0] u_r;

  logic           consume;
  logic [N_W:0]   room;
  logic [N_W:0]   acc_nxt;
  logic [N_W:0]   delta_sum;
  logic [N_W-1:0] r_next;
  logic           sfx_last;

  assign bit_ready = (state == ST_PREFIX) || (state == ST_SUFFIX);
  assign busy      = (state != ST_IDLE);
  assign consume   = bit_valid && bit_ready;
  assign room      = run_room(n_out, t_out);
  assign acc_nxt   = {1'b0, acc} + {2'b0, d_r};
  assign delta_sum = {1'b0, acc} + {1'b0, r_next};

  golomb_suffix_shift #(.R_W(N_W)) u_suffix (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   ((state == ST_PREFIX) && consume && !bit_in),
    .u      (u_r),
    .shift  ((state == ST_SUFFIX) && consume),
    .bit_in (bit_in),
    .r_next (r_next),
    .last   (sfx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      acc         <= '0;
      d_r         <= '0;
      u_r         <= '0;
      n_out       <= '0;
      t_out       <= '0;
      delta       <= '0;
      delta_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_out    <= n_in;
            t_out    <= t_in;
            err      <= 1'b0;
            wait_cnt <= WC_W'(BEST_D_LAT - 1);
            state    <= ST_WAIT_D;
          end
        end
        ST_WAIT_D: begin
          if (wait_cnt == '0) begin
            acc   <= '0;
            d_r   <= d;
            u_r   <= u;
            state <= ST_PREFIX;
          end else begin
            wait_cnt <= wait_cnt - WC_W'(1);
          end
        end
        ST_PREFIX: begin
          if (consume) begin
            if (!bit_in) begin
              state <= ST_SUFFIX;
            end else if (acc_nxt <= room) begin
              acc <= acc_nxt[N_W-1:0];
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_SUFFIX: begin
          if (consume && sfx_last) begin
            if (delta_sum > room) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              delta       <= delta_sum[N_W-1:0];
              delta_valid <= 1'b1;
              state       <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (delta_ready) begin
            n_out       <= n_out - delta - N_W'(1);
            t_out       <= t_out - T_W'(1);
            delta_valid <= 1'b0;
            if (t_out == T_W'(1)) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              wait_cnt <= WC_W'(BEST_D_LAT - 1);
              state    <= ST_WAIT_D;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_run_decoder.sv
// Randomized bench for cw_run_decoder: words are encoded from chosen run
// lengths by a reference encoder, then the decoded deltas are compared.
module tb_cw_run_decoder;
  import cw_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] n_in = '0;
  logic [4:0]  t_in = '0;
  logic [11:0] n_out;
  logic [4:0]  t_out;
  logic [10:0] d;
  logic [3:0]  u;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [11:0] delta;
  logic        delta_valid;
  logic        delta_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  cw_run_decoder #(.BEST_D_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .t_in(t_in),
    .n_out(n_out), .t_out(t_out), .d(d), .u(u),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .delta(delta), .delta_valid(delta_valid), .delta_ready(delta_ready),
    .busy(busy), .done(done), .err(err)
  );

  // best_d stand-in: u = smallest k in 2..10 with 2*t*2^k >= n.
  function automatic int best_u(int n, int t);
    int k;
    k = 2;
    while (k < 10 && 2 * t * (1 << k) < n) k++;
    return k;
  endfunction

  logic [3:0] u_pipe [0:LAT-2];
  always @(posedge clk) begin
    u_pipe[0] <= 4'(best_u(int'(n_out), int'(t_out)));
    for (int i = 1; i < LAT - 1; i++) u_pipe[i] <= u_pipe[i-1];
  end
  assign u = u_pipe[LAT-2];
  assign d = 11'(1) << u;

  int tests = 0;
  int fails = 0;

  task automatic check_val(string tag, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // -1 = overflow in prefix, -2 = overflow in suffix, absent = random run
  int req_q[$];
  bit bits_q[$];
  int exp_delta[$];
  int exp_n[$];
  int exp_t[$];
  int fin_n, fin_t;
  bit exp_err;
  bit force_bp = 0;
  int last_sum, last_got;

  task automatic push_code(int q, int r, int uu);
    repeat (q) bits_q.push_back(1'b1);
    bits_q.push_back(1'b0);
    for (int i = uu - 1; i >= 0; i--) bits_q.push_back(((r >> i) & 1) != 0);
  endtask

  task automatic build_word(int n, int t);
    int nc, tc, uu, dd, room, req, lim;
    nc = n; tc = t; exp_err = 0;
    bits_q.delete(); exp_delta.delete(); exp_n.delete(); exp_t.delete();
    while (tc > 0 && !exp_err) begin
      uu = best_u(nc, tc);
      dd = 1 << uu;
      room = nc - tc;
      if (req_q.size() > 0) req = req_q.pop_front();
      else begin
        lim = 2 * room / tc + 1;
        if (lim > room) lim = room;
        req = $urandom_range(0, lim);
      end
      if (req == -2 && (room % dd) == dd - 1) req = -1;
      if (req == -1) begin
        repeat (room / dd + 1) bits_q.push_back(1'b1);
        exp_err = 1;
      end else if (req == -2) begin
        push_code(room / dd, $urandom_range(room % dd + 1, dd - 1), uu);
        exp_err = 1;
      end else begin
        push_code(req / dd, req % dd, uu);
        exp_delta.push_back(req);
        exp_n.push_back(nc);
        exp_t.push_back(tc);
        nc = nc - req - 1;
        tc--;
      end
    end
    fin_n = nc;
    fin_t = tc;
  endtask

  task automatic run_word(int n, int t);
    int cyc, wcnt, held, bp;
    bit seen_done, hold, acc_prev;
    build_word(n, t);
    cyc = 0; wcnt = 0; held = 0; bp = 0;
    seen_done = 0; hold = 0; acc_prev = 0;
    last_sum = 0; last_got = 0;
    @(negedge clk);
    n_in = 12'(n); t_in = 5'(t); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen_done && cyc < 20000) begin
      if (acc_prev) check_val("dv_drop", int'(delta_valid), 0);
      if (done) seen_done = 1;
      else begin
        if (busy && !bit_ready && !delta_valid) wcnt++;
        else if (bit_ready && wcnt > 0) begin
          check_val("wait_d_len", wcnt, LAT);
          wcnt = 0;
        end
        if (hold) begin
          check_val("valid_hold", int'(delta_valid), 1);
          check_val("delta_hold", int'(delta), held);
          check_val("br_emit", int'(bit_ready), 0);
        end else if (delta_valid) begin
          last_got++;
          last_sum += int'(delta);
          if (exp_delta.size() == 0) check_val("extra_delta", int'(delta), -1);
          else begin
            check_val("delta", int'(delta), exp_delta.pop_front());
            check_val("n_out", int'(n_out), exp_n.pop_front());
            check_val("t_out", int'(t_out), exp_t.pop_front());
          end
        end
      end
      if (!seen_done) begin
        start = ($urandom_range(0, 15) == 0);
        n_in = 12'($urandom_range(1, 4095));
        delta_ready = ($urandom_range(0, 2) != 0);
        if (force_bp && delta_valid && bp < 5) begin
          delta_ready = 1'b0;
          bp++;
        end
        hold = delta_valid && !delta_ready;
        acc_prev = delta_valid && delta_ready;
        if (acc_prev) bp = 0;
        held = int'(delta);
        bit_valid = (bits_q.size() > 0) && ($urandom_range(0, 3) != 0);
        bit_in = bit_valid ? bits_q[0] : 1'($urandom_range(0, 1));
        if (bit_valid && bit_ready) void'(bits_q.pop_front());
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; bit_valid = 1'b0; delta_ready = 1'b0;
    check_val("done_seen", int'(seen_done), 1);
    check_val("err", int'(err), int'(exp_err));
    check_val("fin_n", int'(n_out), fin_n);
    check_val("fin_t", int'(t_out), fin_t);
    check_val("bits_left", bits_q.size(), 0);
    check_val("deltas_left", exp_delta.size(), 0);
    @(negedge clk);
    check_val("done_pulse", int'(done), 0);
    check_val("idle_busy", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check_val({tag, "_nt"}, int'({n_out, t_out}), 0);
    check_val({tag, "_delta"}, int'(delta), 0);
    check_val({tag, "_flags"}, int'({bit_ready, delta_valid, busy, done, err}), 0);
  endtask

  initial begin
    int t, n, wt;
    bit rst_bits[4];
    rst_bits = '{1'b1, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    req_q = '{517};
    run_word(1024, 1);
    check_val("tp1_n", int'(n_out), 506);

    req_q = '{3};
    run_word(1024, 10);

    req_q = '{-1};
    run_word(1024, 1);

    req_q = '{-2};
    run_word(1000, 1);

    req_q = '{99};
    run_word(100, 1);

    run_word(5, 5);

    force_bp = 1;
    run_word(300, 4);
    force_bp = 0;

    // reset in the middle of a suffix
    @(negedge clk);
    n_in = 12'd1024; t_in = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wt = 0;
    while (!bit_ready && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check_val("rst_ready_wait", int'(bit_ready), 1);
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in = rst_bits[i];
      @(negedge clk);
    end
    bit_valid = 1'b0;
    check_val("pre_rst_busy", int'({busy, bit_ready}), 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_word(64, 2);

    run_word(256, 3);
    check_val("sum_bound", int'(last_sum + 3 <= 256), 1);
    check_val("n_deltas", last_got, 3);

    repeat (10) begin
      t = $urandom_range(1, 31);
      n = $urandom_range(t, 4095);
      run_word(n, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
